// File: rtl/csc_row_mvm.sv
// Circulant sparse matrix-vector multiply: expands a 4-term first-row packet into
// MAT_RANK rows, fetches x per term from external RAM and streams y[r] downstream.
module csc_row_mvm #(
   parameter int unsigned MAT_RANK = 256,
   parameter int unsigned FRAC     = 17
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [4*$clog2(MAT_RANK)-1:0] in_col_index,
   input  logic [31:0]                 in_val_r0,
   input  logic [31:0]                 in_val_r1,
   input  logic [31:0]                 in_val_r2,
   input  logic [31:0]                 in_val_r3,
   input  logic [31:0]                 in_val_i0,
   input  logic [31:0]                 in_val_i1,
   input  logic [31:0]                 in_val_i2,
   input  logic [31:0]                 in_val_i3,
   input  logic                        in_vld,
   output logic                        in_rdy,
   output logic                        x_rd_en,
   output logic [$clog2(MAT_RANK)-1:0] x_addr,
   input  logic [31:0]                 x_rdata_r,
   input  logic [31:0]                 x_rdata_i,
   output logic [31:0]                 y_r,
   output logic [31:0]                 y_i,
   output logic [$clog2(MAT_RANK)-1:0] y_row,
   output logic                        y_last,
   output logic                        y_vld,
   input  logic                        y_rdy
);

   localparam int unsigned INDEX_W = $clog2(MAT_RANK);
   localparam int unsigned ACC_W   = 66;
   localparam logic [INDEX_W-1:0] ROW_LAST = INDEX_W'(MAT_RANK - 1);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, OUT} state_t;

   state_t                     state_q;
   logic [INDEX_W-1:0]         row_q;
   logic [1:0]                 k_q;
   logic                       rd_vld_q;
   logic [1:0]                 rd_k_q;
   logic [INDEX_W-1:0]         col_q [4];
   logic signed [31:0]         vr_q [4];
   logic signed [31:0]         vi_q [4];
   logic signed [ACC_W-1:0]    acc_re_q, acc_im_q;
   logic                       in_rdy_q, x_rd_en_q, y_vld_q, y_last_q;
   logic [INDEX_W-1:0]         x_addr_q, y_row_q;
   logic [31:0]                y_r_q, y_i_q;

   logic signed [31:0]         v_r, v_i, xr_s, xi_s;
   logic signed [63:0]         p_rr, p_ii, p_ri, p_ir;
   logic signed [ACC_W-1:0]    term_re, term_im, acc_re_d, acc_im_d;
   logic [31:0]                y_r_d, y_i_d;

   // Complex multiply of the returning x word with the term that requested it.
   always_comb begin
      v_r      = vr_q[rd_k_q];
      v_i      = vi_q[rd_k_q];
      xr_s     = $signed(x_rdata_r);
      xi_s     = $signed(x_rdata_i);
      p_rr     = 64'(v_r) * 64'(xr_s);
      p_ii     = 64'(v_i) * 64'(xi_s);
      p_ri     = 64'(v_r) * 64'(xi_s);
      p_ir     = 64'(v_i) * 64'(xr_s);
      term_re  = ACC_W'(p_rr) - ACC_W'(p_ii);
      term_im  = ACC_W'(p_ri) + ACC_W'(p_ir);
      acc_re_d = acc_re_q;
      acc_im_d = acc_im_q;
      if (rd_vld_q) begin
         acc_re_d = acc_re_q + term_re;
         acc_im_d = acc_im_q + term_im;
      end
      y_r_d    = 32'(acc_re_d >>> FRAC);
      y_i_d    = 32'(acc_im_d >>> FRAC);
   end

   // Row sequencer: issue 4 reads, drain the last return, present y, advance row.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         row_q     <= '0;
         k_q       <= '0;
         rd_vld_q  <= 1'b0;
         rd_k_q    <= '0;
         acc_re_q  <= '0;
         acc_im_q  <= '0;
         in_rdy_q  <= 1'b1;
         x_rd_en_q <= 1'b0;
         x_addr_q  <= '0;
         y_vld_q   <= 1'b0;
         y_last_q  <= 1'b0;
         y_row_q   <= '0;
         y_r_q     <= '0;
         y_i_q     <= '0;
         for (int k = 0; k < 4; k++) begin
            col_q[k] <= '0;
            vr_q[k]  <= '0;
            vi_q[k]  <= '0;
         end
      end else begin
         rd_vld_q <= x_rd_en_q;
         rd_k_q   <= k_q;
         if (rd_vld_q) begin
            acc_re_q <= acc_re_d;
            acc_im_q <= acc_im_d;
         end
         case (state_q)
            IDLE: begin
               if (in_vld && in_rdy_q) begin
                  for (int k = 0; k < 4; k++) col_q[k] <= in_col_index[k*INDEX_W +: INDEX_W];
                  vr_q[0]   <= in_val_r0;
                  vr_q[1]   <= in_val_r1;
                  vr_q[2]   <= in_val_r2;
                  vr_q[3]   <= in_val_r3;
                  vi_q[0]   <= in_val_i0;
                  vi_q[1]   <= in_val_i1;
                  vi_q[2]   <= in_val_i2;
                  vi_q[3]   <= in_val_i3;
                  row_q     <= '0;
                  k_q       <= '0;
                  acc_re_q  <= '0;
                  acc_im_q  <= '0;
                  in_rdy_q  <= 1'b0;
                  x_rd_en_q <= 1'b1;
                  x_addr_q  <= in_col_index[INDEX_W-1:0];
                  state_q   <= FETCH;
               end
            end
            FETCH: begin
               if (k_q == 2'd3) begin
                  x_rd_en_q <= 1'b0;
                  state_q   <= DRAIN;
               end else begin
                  k_q      <= 2'(k_q + 2'd1);
                  x_addr_q <= INDEX_W'(col_q[2'(k_q + 2'd1)] + row_q);
               end
            end
            DRAIN: begin
               y_r_q    <= y_r_d;
               y_i_q    <= y_i_d;
               y_row_q  <= row_q;
               y_last_q <= (row_q == ROW_LAST);
               y_vld_q  <= 1'b1;
               state_q  <= OUT;
            end
            OUT: begin
               if (y_rdy) begin
                  y_vld_q  <= 1'b0;
                  y_last_q <= 1'b0;
                  if (row_q == ROW_LAST) begin
                     in_rdy_q <= 1'b1;
                     state_q  <= IDLE;
                  end else begin
                     row_q     <= INDEX_W'(row_q + 1'b1);
                     k_q       <= '0;
                     acc_re_q  <= '0;
                     acc_im_q  <= '0;
                     x_rd_en_q <= 1'b1;
                     x_addr_q  <= INDEX_W'(col_q[0] + row_q + 1'b1);
                     state_q   <= FETCH;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_rdy  = in_rdy_q;
   assign x_rd_en = x_rd_en_q;
   assign x_addr  = x_addr_q;
   assign y_r     = y_r_q;
   assign y_i     = y_i_q;
   assign y_row   = y_row_q;
   assign y_last  = y_last_q;
   assign y_vld   = y_vld_q;

endmodule

// File: tb/tb_csc_row_mvm.sv
// Bench for csc_row_mvm at MAT_RANK=8: directed table vectors, random packets against
// an arithmetic circulant model, backpressure, busy-input, sign and reset corners.
module tb_csc_row_mvm;

   localparam int unsigned R   = 8;
   localparam int unsigned IW  = 3;
   localparam int          ONE = 131072;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [4*IW-1:0] in_col_index;
   logic [31:0]     in_val_r0, in_val_r1, in_val_r2, in_val_r3;
   logic [31:0]     in_val_i0, in_val_i1, in_val_i2, in_val_i3;
   logic            in_vld, in_rdy, x_rd_en;
   logic [IW-1:0]   x_addr, y_row;
   logic [31:0]     x_rdata_r, x_rdata_i, y_r, y_i;
   logic            y_last, y_vld, y_rdy;

   csc_row_mvm #(.MAT_RANK(R), .FRAC(17)) dut (
      .clk(clk), .rst_n(rst_n), .in_col_index(in_col_index),
      .in_val_r0(in_val_r0), .in_val_r1(in_val_r1), .in_val_r2(in_val_r2), .in_val_r3(in_val_r3),
      .in_val_i0(in_val_i0), .in_val_i1(in_val_i1), .in_val_i2(in_val_i2), .in_val_i3(in_val_i3),
      .in_vld(in_vld), .in_rdy(in_rdy), .x_rd_en(x_rd_en), .x_addr(x_addr),
      .x_rdata_r(x_rdata_r), .x_rdata_i(x_rdata_i), .y_r(y_r), .y_i(y_i),
      .y_row(y_row), .y_last(y_last), .y_vld(y_vld), .y_rdy(y_rdy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic signed [31:0] vr [4];
      logic signed [31:0] vi [4];
      logic [IW-1:0]      col [4];
      logic signed [31:0] xr [R];
      logic signed [31:0] xi [R];
      int                 chk_row;
      logic [31:0]        er;
      logic [31:0]        ei;
   } vec_t;

   logic signed [31:0] pv_r [4], pv_i [4];
   logic [IW-1:0]      pcol [4];
   logic signed [31:0] xr_mem [R], xi_mem [R];
   logic [31:0]        mdl_r [R], mdl_i [R], cap_r [R], cap_i [R];
   vec_t               vt [5];
   int                 checks = 0, errors = 0, cyc = 0;
   int                 acc_cyc_q [$];
   int                 hs_cyc_q [$];

   // x RAM: one-cycle read latency, garbage when no read was issued
   always @(posedge clk) begin
      if (x_rd_en) begin
         x_rdata_r <= xr_mem[x_addr];
         x_rdata_i <= xi_mem[x_addr];
      end else begin
         x_rdata_r <= $urandom;
         x_rdata_i <= $urandom;
      end
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst_n && in_vld && in_rdy) acc_cyc_q.push_back(cyc);
      if (rst_n && y_vld && y_rdy)   hs_cyc_q.push_back(cyc);
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   // y[r] = sum_k v_k * x[(c_k + r) mod R], floored by 2^17, low 32 bits
   task automatic model_compute();
      logic signed [65:0] ar, ai, sh;
      int n;
      for (int r = 0; r < R; r++) begin
         ar = '0;
         ai = '0;
         for (int k = 0; k < 4; k++) begin
            n  = (int'(pcol[k]) + r) % R;
            ar = ar + 66'(pv_r[k]) * 66'(xr_mem[n]) - 66'(pv_i[k]) * 66'(xi_mem[n]);
            ai = ai + 66'(pv_r[k]) * 66'(xi_mem[n]) + 66'(pv_i[k]) * 66'(xr_mem[n]);
         end
         sh = ar >>> 17;
         mdl_r[r] = sh[31:0];
         sh = ai >>> 17;
         mdl_i[r] = sh[31:0];
      end
   endtask

   task automatic rand_pkt();
      for (int k = 0; k < 4; k++) begin
         pcol[k] = IW'($urandom_range(0, R - 1));
         pv_r[k] = $urandom;
         pv_i[k] = $urandom;
      end
      for (int n = 0; n < R; n++) begin
         xr_mem[n] = $urandom;
         xi_mem[n] = $urandom;
      end
   endtask

   task automatic drive_pkt();
      in_col_index = {pcol[3], pcol[2], pcol[1], pcol[0]};
      in_val_r0 = pv_r[0]; in_val_r1 = pv_r[1]; in_val_r2 = pv_r[2]; in_val_r3 = pv_r[3];
      in_val_i0 = pv_i[0]; in_val_i1 = pv_i[1]; in_val_i2 = pv_i[2]; in_val_i3 = pv_i[3];
   endtask

   task automatic send_pkt();
      int n;
      @(negedge clk);
      drive_pkt();
      in_vld = 1'b1;
      n = 0;
      while (!in_rdy && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (!in_rdy) chk("in_rdy_timeout", 64'(in_rdy), 64'd1);
      @(posedge clk);
      @(negedge clk);
      in_vld = 1'b0;
   endtask

   // Collect nrows results; optionally stall the sink at stall_row for stall_len cycles
   task automatic collect(input int nrows, input int stall_row, input int stall_len);
      int n;
      logic [31:0]   hr, hi;
      logic [IW-1:0] hrow;
      for (int r = 0; r < nrows; r++) begin
         n = 0;
         while (!y_vld && n < 100) begin
            @(negedge clk);
            n++;
         end
         if (!y_vld) begin
            chk("y_vld_timeout", 64'(y_vld), 64'd1);
            return;
         end
         if (r == 0) chk("latency", 64'(cyc - acc_cyc_q[$]), 64'd6);
         chk("in_rdy_busy", 64'(in_rdy), 64'd0);
         if (r == stall_row) begin
            y_rdy = 1'b0;
            hr = y_r; hi = y_i; hrow = y_row;
            for (int s = 0; s < stall_len; s++) begin
               @(negedge clk);
               chk("stall_y", {y_r, y_i}, {hr, hi});
               chk("stall_ctl", 64'({y_vld, x_rd_en, y_row}), 64'({1'b1, 1'b0, hrow}));
            end
            y_rdy = 1'b1;
         end
         chk("y_r", 64'(y_r), 64'(mdl_r[r]));
         chk("y_i", 64'(y_i), 64'(mdl_i[r]));
         chk("y_row", 64'(y_row), 64'(r));
         chk("y_last", 64'(y_last), 64'(r == R - 1));
         cap_r[r] = y_r;
         cap_i[r] = y_i;
         @(negedge clk);
         if (r == stall_row) chk("resume_rd", 64'(x_rd_en), 64'd1);
         if (r == R - 1) chk("idle_rdy", 64'(in_rdy), 64'd1);
         else            chk("vld_drop", 64'(y_vld), 64'd0);
      end
   endtask

   initial begin
      rst_n = 1'b0; in_vld = 1'b0; y_rdy = 1'b1;
      in_col_index = '0;
      in_val_r0 = '0; in_val_r1 = '0; in_val_r2 = '0; in_val_r3 = '0;
      in_val_i0 = '0; in_val_i1 = '0; in_val_i2 = '0; in_val_i3 = '0;

      for (int i = 0; i < 5; i++) begin
         for (int k = 0; k < 4; k++) begin
            vt[i].vr[k] = '0; vt[i].vi[k] = '0; vt[i].col[k] = IW'(k);
         end
         for (int n = 0; n < R; n++) begin
            vt[i].xr[n] = '0; vt[i].xi[n] = '0;
         end
         vt[i].chk_row = 0; vt[i].er = '0; vt[i].ei = '0;
      end
      // real circulant, rows 0 and 7
      for (int i = 0; i < 2; i++) begin
         for (int k = 0; k < 4; k++) vt[i].vr[k] = ONE;
         vt[i].col[0] = 3'd0; vt[i].col[1] = 3'd1; vt[i].col[2] = 3'd4; vt[i].col[3] = 3'd5;
         for (int n = 0; n < R; n++) vt[i].xr[n] = n * ONE;
      end
      vt[0].chk_row = 0; vt[0].er = 32'd1310720;
      vt[1].chk_row = 7; vt[1].er = 32'd1835008;
      // j * j = -1
      vt[2].vi[0] = ONE; vt[2].xi[0] = ONE; vt[2].er = 32'hFFFE_0000;
      // j * 1 = j
      vt[3].vi[0] = ONE; vt[3].xr[0] = ONE; vt[3].ei = 32'd131072;
      // -1 LSB * 1 LSB floors to -1
      vt[4].vr[0] = -32'sd1; vt[4].xr[0] = 32'sd1; vt[4].er = 32'hFFFF_FFFF;

      repeat (3) @(negedge clk);
      chk("rst_in_rdy", 64'(in_rdy), 64'd1);
      chk("rst_ctl", 64'({x_rd_en, x_addr, y_vld, y_last, y_row}), 64'd0);
      chk("rst_y", {y_r, y_i}, 64'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 5; i++) begin
         pv_r = vt[i].vr; pv_i = vt[i].vi; pcol = vt[i].col;
         xr_mem = vt[i].xr; xi_mem = vt[i].xi;
         model_compute();
         send_pkt();
         collect(R, -1, 0);
         chk("tbl_y_r", 64'(cap_r[vt[i].chk_row]), 64'(vt[i].er));
         chk("tbl_y_i", 64'(cap_i[vt[i].chk_row]), 64'(vt[i].ei));
      end

      // backpressure at row 3
      rand_pkt();
      model_compute();
      send_pkt();
      collect(R, 3, 10);

      // input held valid across two packets
      rand_pkt();
      model_compute();
      acc_cyc_q.delete();
      hs_cyc_q.delete();
      @(negedge clk);
      drive_pkt();
      in_vld = 1'b1;
      collect(R, -1, 0);
      @(posedge clk);
      @(negedge clk);
      in_vld = 1'b0;
      collect(R, -1, 0);
      chk("accept_count", 64'(acc_cyc_q.size()), 64'd2);
      chk("hs_count", 64'(hs_cyc_q.size()), 64'(2 * R));
      if (acc_cyc_q.size() == 2 && hs_cyc_q.size() >= R) begin
         chk("accept_after_last", 64'(acc_cyc_q[1] - hs_cyc_q[R-1]), 64'd1);
         chk("pkt_cycles", 64'(hs_cyc_q[R-1] - acc_cyc_q[0]), 64'(6 * R));
      end

      for (int p = 0; p < 5; p++) begin
         rand_pkt();
         model_compute();
         send_pkt();
         collect(R, -1, 0);
      end

      // reset in row 2 FETCH, then a clean packet
      rand_pkt();
      model_compute();
      send_pkt();
      collect(2, -1, 0);
      @(negedge clk);
      chk("pre_rst_fetch", 64'(x_rd_en), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_in_rdy", 64'(in_rdy), 64'd1);
      chk("mid_rst_ctl", 64'({x_rd_en, x_addr, y_vld, y_last, y_row}), 64'd0);
      chk("mid_rst_y", {y_r, y_i}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      rand_pkt();
      model_compute();
      send_pkt();
      collect(R, -1, 0);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
